// File: rtl/fir_stream_mac_if.sv
// Valid/ready stream bundle for fir_stream_mac:
// sample input side (s_*) and result output side (m_*).
interface fir_stream_mac_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);
  logic signed [DATA_W-1:0] s_tdata;
  logic                     s_tvalid;
  logic                     s_tready;
  logic signed [OUT_W-1:0]  m_tdata;
  logic                     m_tvalid;
  logic                     m_tready;

  modport master (
    output s_tdata,
    output s_tvalid,
    input  s_tready,
    input  m_tdata,
    input  m_tvalid,
    output m_tready
  );

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    output s_tready,
    output m_tdata,
    output m_tvalid,
    input  m_tready
  );
endinterface

// File: rtl/fir_stream_mac.sv
// Streaming FIR filter: one shared multiplier walks TAPS taps per
// sample, then holds the scaled result until downstream takes it.
module fir_stream_mac #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int TAPS     = 8,
  parameter int OUT_W    = 8,
  parameter int SHIFT    = 6,
  parameter bit SATURATE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fir_stream_mac_if.slave           bus,
  input  logic                      coef_wr,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      busy
);
  localparam int AW    = $clog2(TAPS);
  localparam int IW    = $clog2(TAPS + 1);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + AW;
  localparam logic signed [ACC_W-1:0] OMAX =
    ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;
  localparam logic signed [COEF_W-1:0] C_ONE =
    COEF_W'(1 << SHIFT);

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_e;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [DATA_W-1:0] x_d [TAPS];
  logic signed [COEF_W-1:0] c_q [TAPS];
  logic signed [COEF_W-1:0] c_d [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic signed [OUT_W-1:0]  m_tdata_q, m_tdata_d;
  logic                     m_tvalid_q, m_tvalid_d;

  logic [AW-1:0]            tap;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  sh;
  logic signed [OUT_W-1:0]  scaled;
  logic                     last;

  assign tap  = idx_q[AW-1:0];
  assign prod = x_q[tap] * c_q[tap];
  // idx reaches TAPS one edge after the final MAC: that edge loads the output
  assign last = (idx_q == IW'(TAPS));
  assign sh   = acc_q >>> SHIFT;

  always_comb begin
    unique case (1'b1)
      SATURATE && (sh > OMAX): scaled = OMAX[OUT_W-1:0];
      SATURATE && (sh < OMIN): scaled = OMIN[OUT_W-1:0];
      default:                 scaled = sh[OUT_W-1:0];
    endcase
  end

  assign bus.s_tready = (state_q == IDLE);
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign busy         = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.s_tvalid) state_d = MAC;
      MAC:     if (last) state_d = HOLD;
      HOLD:    if (bus.m_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d        = x_q;
    c_d        = c_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    unique case (state_q)
      IDLE: begin
        if (coef_wr && (int'(coef_addr) < TAPS))
          c_d[coef_addr] = coef_data;
        if (bus.s_tvalid) begin
          for (int k = TAPS - 1; k > 0; k--)
            x_d[k] = x_q[k-1];
          x_d[0] = bus.s_tdata;
          acc_d  = '0;
          idx_d  = '0;
        end
      end
      MAC: begin
        if (last) begin
          m_tdata_d  = scaled;
          m_tvalid_d = 1'b1;
        end else begin
          acc_d = acc_q + ACC_W'(prod);
          idx_d = idx_q + 1'b1;
        end
      end
      HOLD: if (bus.m_tready) m_tvalid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= (k == 0) ? C_ONE : '0;
      end
      acc_q      <= '0;
      idx_q      <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      c_q        <= c_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end
endmodule

// File: tb/tb_fir_stream_mac.sv
// Bench for fir_stream_mac: a default instance and a TAPS=6 wrapping
// instance, both checked each cycle against a convolution model.
module tb_fir_stream_mac;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_stream_mac_if #(.DATA_W(8), .OUT_W(8)) if0 ();
  fir_stream_mac_if #(.DATA_W(8), .OUT_W(8)) if1 ();

  logic signed [7:0] td [2];
  logic              tv [2];
  logic              mr [2];
  logic              cw [2];
  logic [2:0]        ca [2];
  logic signed [7:0] cd [2];
  logic              rdy [2];
  logic              mv [2];
  logic              bsy [2];
  logic signed [7:0] md [2];

  assign if0.s_tdata  = td[0];
  assign if0.s_tvalid = tv[0];
  assign if0.m_tready = mr[0];
  assign rdy[0]       = if0.s_tready;
  assign mv[0]        = if0.m_tvalid;
  assign md[0]        = if0.m_tdata;
  assign if1.s_tdata  = td[1];
  assign if1.s_tvalid = tv[1];
  assign if1.m_tready = mr[1];
  assign rdy[1]       = if1.s_tready;
  assign mv[1]        = if1.m_tvalid;
  assign md[1]        = if1.m_tdata;

  fir_stream_mac u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0),
    .coef_wr(cw[0]), .coef_addr(ca[0]),
    .coef_data(cd[0]), .busy(bsy[0])
  );

  fir_stream_mac #(.TAPS(6), .SATURATE(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1),
    .coef_wr(cw[1]), .coef_addr(ca[1]),
    .coef_data(cd[1]), .busy(bsy[1])
  );

  int ntest = 0;
  int nfail = 0;
  int cyc = 0;
  int tapsn [2] = '{8, 6};
  bit satn [2] = '{1'b1, 1'b0};
  int xm [2][8];
  int cm [2][8];
  bit infl [2];
  int left [2];
  int expq [2][$];
  int logq [2][$];
  int acc_at [2][$];
  int n_acc [2] = '{0, 0};
  int want [$];
  bit rand_mr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    ntest++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int scale(input int a, input bit sat);
    int t;
    t = a >>> 6;
    if (sat) begin
      if (t > 127) t = 127;
      if (t < -128) t = -128;
    end else begin
      t = t & 255;
      if (t > 127) t -= 256;
    end
    return t;
  endfunction

  task automatic mreset(input int d);
    for (int k = 0; k < 8; k++) begin
      xm[d][k] = 0;
      cm[d][k] = 0;
    end
    cm[d][0] = 64;
    infl[d] = 1'b0;
    left[d] = 0;
    expq[d].delete();
  endtask

  // Predict what the next rising edge does to model state.
  task automatic upd(input int d);
    int a;
    if (infl[d]) begin
      if (left[d] > 0) left[d]--;
      else if (mr[d]) begin
        logq[d].push_back(expq[d].pop_front());
        infl[d] = 1'b0;
      end
    end else begin
      if (cw[d] && int'(ca[d]) < tapsn[d])
        cm[d][ca[d]] = int'(cd[d]);
      if (tv[d]) begin
        for (int k = 7; k > 0; k--) xm[d][k] = xm[d][k-1];
        xm[d][0] = int'(td[d]);
        a = 0;
        for (int k = 0; k < tapsn[d]; k++)
          a += xm[d][k] * cm[d][k];
        expq[d].push_back(scale(a, satn[d]));
        acc_at[d].push_back(cyc + 1);
        n_acc[d]++;
        infl[d] = 1'b1;
        left[d] = tapsn[d] + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk($sformatf("rst_mv%0d", d), int'(mv[d]), 0);
        chk($sformatf("rst_rdy%0d", d), int'(rdy[d]), 1);
        chk($sformatf("rst_busy%0d", d), int'(bsy[d]), 0);
        chk($sformatf("rst_data%0d", d), int'(md[d]), 0);
        mreset(d);
      end else begin
        chk($sformatf("s_tready%0d", d), int'(rdy[d]), int'(!infl[d]));
        chk($sformatf("busy%0d", d), int'(bsy[d]), int'(infl[d]));
        chk($sformatf("m_tvalid%0d", d), int'(mv[d]),
            int'(infl[d] && left[d] == 0));
        if (infl[d] && left[d] == 0 && expq[d].size() > 0)
          chk($sformatf("m_tdata%0d", d), int'(md[d]), expq[d][0]);
        upd(d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mr) begin
      mr[0] = 1'($urandom_range(0, 1));
      mr[1] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input int d, input int v);
    int base;
    int n;
    base = n_acc[d];
    n = 0;
    td[d] = 8'(v);
    tv[d] = 1'b1;
    while (n_acc[d] == base && n < 200) begin
      tick();
      n++;
    end
    tv[d] = 1'b0;
    cw[d] = 1'b0;
    chk($sformatf("accept_wait%0d", d), int'(n < 200), 1);
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (infl[d] && n < 300) begin
      tick();
      n++;
    end
    chk($sformatf("idle_wait%0d", d), int'(n < 300), 1);
  endtask

  task automatic wr_coef(input int d, input int a, input int v);
    cw[d] = 1'b1;
    ca[d] = 3'(a);
    cd[d] = 8'(v);
    tick();
    cw[d] = 1'b0;
  endtask

  task automatic chk_log(input int d, input string nm);
    chk({nm, "_count"}, logq[d].size(), want.size());
    for (int i = 0; i < want.size() && i < logq[d].size(); i++)
      chk($sformatf("%s[%0d]", nm, i), logq[d][i], want[i]);
    logq[d].delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      logq[d].delete();
      acc_at[d].delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      td[d] = '0; tv[d] = 1'b0; mr[d] = 1'b1;
      cw[d] = 1'b0; ca[d] = '0; cd[d] = '0;
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    send(0, 5); send(0, -3); send(0, 127); send(0, -128);
    wait_idle(0);
    want = '{5, -3, 127, -128};
    chk_log(0, "ident");
    chk("period_a", acc_at[0][1] - acc_at[0][0], 11);
    chk("period_b", acc_at[0][3] - acc_at[0][2], 11);
    send(1, 9); send(1, -9);
    wait_idle(1);
    want = '{9, -9};
    chk_log(1, "ident6");
    chk("period6", acc_at[1][1] - acc_at[1][0], 9);

    do_reset();
    for (int k = 0; k < 8; k++) wr_coef(0, k, 64);
    send(0, 10);
    for (int k = 0; k < 8; k++) send(0, 0);
    wait_idle(0);
    want = '{10, 10, 10, 10, 10, 10, 10, 10, 0};
    chk_log(0, "impulse");

    do_reset();
    for (int k = 0; k < 8; k++) wr_coef(0, k, 64);
    for (int k = 0; k < 6; k++) wr_coef(1, k, 64);
    repeat (4) send(0, 100);
    wait_idle(0);
    want = '{100, 127, 127, 127};
    chk_log(0, "sat");
    repeat (4) send(1, 100);
    wait_idle(1);
    want = '{100, -56, 44, -112};
    chk_log(1, "wrap");

    do_reset();
    mr[0] = 1'b0;
    send(0, 33);
    td[0] = 8'(44);
    tv[0] = 1'b1;
    n = 0;
    while (!(infl[0] && left[0] == 0) && n < 50) begin
      tick();
      n++;
    end
    chk("bp_reach_hold", int'(n < 50), 1);
    base = n_acc[0];
    repeat (5) tick();
    chk("bp_no_accept", n_acc[0] - base, 0);
    chk("bp_no_output", logq[0].size(), 0);
    mr[0] = 1'b1;
    send(0, 44);
    wait_idle(0);
    want = '{33, 44};
    chk_log(0, "bp");

    do_reset();
    send(0, 20);
    tick();
    tick();
    wr_coef(0, 1, 64);
    wait_idle(0);
    send(0, 30);
    wait_idle(0);
    cw[0] = 1'b1; ca[0] = 3'd0; cd[0] = 8'sd32;
    send(0, 40);
    wait_idle(0);
    want = '{20, 30, 20};
    chk_log(0, "guard");
    wr_coef(1, 7, 64);
    wr_coef(1, 6, 64);
    send(1, 11); send(1, 22);
    wait_idle(1);
    want = '{11, 22};
    chk_log(1, "addr_guard");

    do_reset();
    wr_coef(0, 0, 32);
    wr_coef(0, 3, 64);
    send(0, 50);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_mv", int'(mv[0]), 0);
    chk("mid_rdy", int'(rdy[0]), 1);
    chk("mid_busy", int'(bsy[0]), 0);
    tick();
    rst_n = 1'b1;
    tick();
    logq[0].delete();
    logq[1].delete();
    send(0, 7);
    wait_idle(0);
    want = '{7};
    chk_log(0, "post_rst");

    do_reset();
    rand_mr = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 3) == 0)
          wr_coef(d, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
        send(d, int'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    rand_mr = 1'b0;
    mr[0] = 1'b1;
    mr[1] = 1'b1;
    wait_idle(0);
    wait_idle(1);
    chk("drained0", expq[0].size(), 0);
    chk("drained1", expq[1].size(), 0);
    chk("rand_out0", logq[0].size(), 40);
    chk("rand_out1", logq[1].size(), 40);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule

// File: doc/fir_stream_mac.md
Name: fir_stream_mac

Overview:
- Parametrised, sequential-MAC FIR filter with valid/ready streaming on input and output, and run-time loadable coefficients.
- Next-generation filter core for the tt_um top-level wrapper: samples arrive from ui_in-style buses, results go to the segment/bidir outputs.
- One multiplier is time-shared across TAPS cycles per sample, trading throughput for area.

Parameters:
- DATA_W, 8, signed input sample width
- COEF_W, 8, signed coefficient width
- TAPS, 8, number of filter taps (>=2)
- OUT_W, 8, signed output width
- SHIFT, 6, arithmetic right shift applied to accumulator before output; must be < COEF_W-1
- SATURATE, 1, 1 = clamp output to signed OUT_W range; 0 = keep low OUT_W bits (wrap)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_tdata  in  DATA_W  signed input sample
- s_tvalid  in  1  input sample valid
- s_tready  out  1  block can accept a sample
- m_tdata  out  OUT_W  signed filtered result
- m_tvalid  out  1  result valid
- m_tready  in  1  downstream accepts result
- coef_wr  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  tap index to write
- coef_data  in  COEF_W  signed coefficient value
- busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- Reset (asynchronous, any time including mid-MAC):
  - delay line x[0..TAPS-1] = 0; accumulator = 0; tap index = 0
  - c[0] = 1<<SHIFT, all other c[k] = 0, so the filter is identity after reset
  - state = IDLE; outputs: s_tready=1, m_tvalid=0, m_tdata=0, busy=0
- FSM states: IDLE, MAC, HOLD.
- IDLE:
  - s_tready=1.
  - On s_tvalid&&s_tready (edge E0): shift delay line (x[k]<=x[k-1], x[0]<=s_tdata), acc<=0, idx<=0, go to MAC.
- MAC:
  - s_tready=0.
  - On each of edges E1..E_TAPS: acc <= acc + x[idx]*c[idx] (signed full-precision product), idx++.
  - After E_TAPS: go to HOLD.
- HOLD entry (edge E_TAPS+1): m_tdata <= scale(acc), m_tvalid <= 1.
  - m_tdata and m_tvalid stay stable until m_tready=1.
  - On the handshake edge: m_tvalid<=0, go to IDLE.
- Latency: m_tvalid first high in the cycle after edge E_TAPS+1, i.e. TAPS+1 edges after acceptance.
  - With m_tready tied high: one sample per TAPS+3 cycles.
- Accumulator width: DATA_W+COEF_W+$clog2(TAPS). It never overflows internally.
- scale(acc):
  - t = acc >>> SHIFT (arithmetic, rounds toward -inf).
  - SATURATE=1: clamp t to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - SATURATE=0: t[OUT_W-1:0].
- Coefficient writes:
  - Accepted only in IDLE; c[coef_addr] <= coef_data on the same edge.
  - coef_wr outside IDLE is ignored.
  - coef_addr >= TAPS is ignored.
  - Simultaneous coef_wr and sample accept in IDLE: the new coefficient is used for that sample.
- Backpressure: while in HOLD with m_tready=0, no input is accepted (s_tready=0) and no sample is lost.
- s_tvalid while s_tready=0: the source must hold data; the block does not sample it.

Test Plan:
- Reset identity (defaults): send 5, -3, 127, -128 with m_tready=1 -> m_tdata 5, -3, 127, -128; each m_tvalid rises 9 edges after its accept; s_tready period 11 cycles.
- Impulse response: write c[0..7]=64, then send 10 followed by 8 zeros -> outputs 10 ×8, then 0.
- Saturation: c[0..7]=64, send 100 ×4 -> outputs 100, 127, 127, 127. Then with SATURATE=0 the same stimulus gives 100, -56, 44, -112 (low 8 bits of 200, 300, 400).
- Backpressure: hold m_tready=0 for 5 cycles after m_tvalid rises -> m_tdata stable, s_tready=0, busy=1; the next sample is accepted only after the handshake, and no result is dropped or duplicated.
- Coefficient guard: coef_wr c[1]=64 during MAC -> ignored (identity output preserved). Write with coef_addr >= TAPS (e.g. TAPS=6, addr 7) -> ignored.
- Reset mid-MAC: assert rst_n=0 at E3 -> immediately m_tvalid=0, s_tready=1, busy=0. After release, send 7 -> output 7 (identity coefficients and delay line restored).
